// File: rtl/min_pair_stream_sorter.sv
// Streaming 4-sample frame reducer: returns the two smallest magnitudes of each
// frame with their in-frame indices; ties favour the later sample.
module min_pair_stream_sorter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min0,
    output logic [1:0]       out_idx0,
    output logic [WIDTH-1:0] out_min1,
    output logic [1:0]       out_idx1
);

    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_wmin0;
    logic [WIDTH-1:0] r_wmin1;
    logic [1:0]       r_widx0;
    logic [1:0]       r_widx1;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_min0;
    logic [WIDTH-1:0] r_out_min1;
    logic [1:0]       r_out_idx0;
    logic [1:0]       r_out_idx1;

    logic             w_accept;
    logic             w_complete;
    logic             w_in_ready;
    logic [WIDTH-1:0] w_nmin0;
    logic [WIDTH-1:0] w_nmin1;
    logic [1:0]       w_nidx0;
    logic [1:0]       w_nidx1;

    // The 4th sample may only enter when the output slot is free or draining now
    assign w_in_ready = !((r_cnt == 2'd3) && r_out_valid && !out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_complete = w_accept && (r_cnt == 2'd3);

    // Insertion of the incoming sample into the running two-smallest pair
    always_comb begin
        w_nmin0 = r_wmin0;
        w_nidx0 = r_widx0;
        w_nmin1 = r_wmin1;
        w_nidx1 = r_widx1;
        case (r_cnt)
            2'd0: begin
                w_nmin0 = in_mag;
                w_nidx0 = 2'd0;
                w_nmin1 = {WIDTH{1'b0}};
                w_nidx1 = 2'd0;
            end
            2'd1: begin
                if (in_mag <= r_wmin0) begin
                    w_nmin1 = r_wmin0;
                    w_nidx1 = r_widx0;
                    w_nmin0 = in_mag;
                    w_nidx0 = 2'd1;
                end else begin
                    w_nmin1 = in_mag;
                    w_nidx1 = 2'd1;
                end
            end
            default: begin
                if (in_mag <= r_wmin0) begin
                    w_nmin1 = r_wmin0;
                    w_nidx1 = r_widx0;
                    w_nmin0 = in_mag;
                    w_nidx0 = r_cnt;
                end else if (in_mag <= r_wmin1) begin
                    w_nmin1 = in_mag;
                    w_nidx1 = r_cnt;
                end else begin
                    w_nmin1 = r_wmin1;
                    w_nidx1 = r_widx1;
                end
            end
        endcase
    end

    // Frame counter and working pair; the final sample bypasses into the output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 2'd0;
            r_wmin0 <= {WIDTH{1'b0}};
            r_wmin1 <= {WIDTH{1'b0}};
            r_widx0 <= 2'd0;
            r_widx1 <= 2'd0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt != 2'd3) begin
                r_wmin0 <= w_nmin0;
                r_wmin1 <= w_nmin1;
                r_widx0 <= w_nidx0;
                r_widx1 <= w_nidx1;
            end
        end
    end

    // Output slot: loads on frame completion, empties on transfer otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_min0  <= {WIDTH{1'b0}};
            r_out_min1  <= {WIDTH{1'b0}};
            r_out_idx0  <= 2'd0;
            r_out_idx1  <= 2'd0;
        end else if (w_complete) begin
            r_out_valid <= 1'b1;
            r_out_min0  <= w_nmin0;
            r_out_min1  <= w_nmin1;
            r_out_idx0  <= w_nidx0;
            r_out_idx1  <= w_nidx1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_min0  = r_out_min0;
    assign out_idx0  = r_out_idx0;
    assign out_min1  = r_out_min1;
    assign out_idx1  = r_out_idx1;

endmodule

// File: tb/tb_min_pair_stream_sorter.sv
// Scoreboard bench for min_pair_stream_sorter: directed frames push expected
// pairs, a negedge monitor pops and compares on each output transfer.
module tb_min_pair_stream_sorter;

    typedef struct packed {
        logic [3:0] min0;
        logic [1:0] idx0;
        logic [3:0] min1;
        logic [1:0] idx1;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_mag;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_min0;
    logic [1:0] out_idx0;
    logic [3:0] out_min1;
    logic [1:0] out_idx1;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    int   stalls;
    bit   rnd_ready;

    min_pair_stream_sorter #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mag(in_mag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_min0(out_min0), .out_idx0(out_idx0),
        .out_min1(out_min1), .out_idx1(out_idx1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every output transfer must match the oldest pending expectation
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                got = '{out_min0, out_idx0, out_min1, out_idx1};
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_result: got %0d/%0d %0d/%0d, expected none",
                             out_min0, out_idx0, out_min1, out_idx1);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        miscompares++;
                        $display("FAIL result: got %0d/%0d %0d/%0d, expected %0d/%0d %0d/%0d",
                                 got.min0, got.idx0, got.min1, got.idx1,
                                 e.min0, e.idx0, e.min1, e.idx1);
                    end
                end
            end
        end
    end

    // Drive one sample; returns one time step after the accepting edge
    task automatic send(input logic [3:0] x);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_mag   = x;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stalls++;
            n++;
            if (n > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: sample %0d not accepted, expected accept", x);
                break;
            end
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] d, input bit push, input exp_t e);
        if (push) exp_q.push_back(e);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    // Reference: smallest value, ties to highest index, then the same over the rest
    function automatic exp_t ref_pair(input logic [3:0][3:0] v);
        exp_t r;
        int   i0;
        int   i1;
        i0 = 0;
        for (int i = 1; i < 4; i++) if (v[i] <= v[i0]) i0 = i;
        i1 = (i0 == 0) ? 1 : 0;
        for (int i = 0; i < 4; i++) if (i != i0 && v[i] <= v[i1]) i1 = i;
        r.min0 = v[i0];
        r.idx0 = 2'(i0);
        r.min1 = v[i1];
        r.idx1 = 2'(i1);
        return r;
    endfunction

    initial begin
        logic [3:0][3:0] v;
        int              n;
        vectors     = 0;
        miscompares = 0;
        stalls      = 0;
        rnd_ready   = 1'b0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_mag      = 4'd0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_outputs", {20'd0, out_min0, out_idx0, out_min1, out_idx1}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame and latency
        frame(4'd5, 4'd3, 4'd9, 4'd1, 1'b1, '{4'd1, 2'd3, 4'd3, 2'd1});
        check("latency_valid", 32'(out_valid), 32'd1);
        frame(4'd7, 4'd7, 4'd7, 4'd7, 1'b1, '{4'd7, 2'd3, 4'd7, 2'd2});
        frame(4'd2, 4'd2, 4'd8, 4'd8, 1'b1, '{4'd2, 2'd1, 4'd2, 2'd0});

        // Back-to-back frames must never stall
        stalls = 0;
        frame(4'd4, 4'd1, 4'd6, 4'd0, 1'b1, '{4'd0, 2'd3, 4'd1, 2'd1});
        frame(4'd15, 4'd14, 4'd13, 4'd12, 1'b1, '{4'd12, 2'd3, 4'd13, 2'd2});
        check("b2b_no_stall", 32'(stalls), 32'd0);
        @(posedge clk);
        #1;

        // Held result with blocked 4th sample, then simultaneous drain and load
        out_ready = 1'b0;
        frame(4'd6, 4'd2, 4'd2, 4'd5, 1'b1, '{4'd2, 2'd2, 4'd2, 2'd1});
        check("hold_valid", 32'(out_valid), 32'd1);
        stalls = 0;
        send(4'd10);
        send(4'd11);
        send(4'd12);
        check("hold_three_accepted", 32'(stalls), 32'd0);
        exp_q.push_back('{4'd0, 2'd3, 4'd10, 2'd0});
        in_valid = 1'b1;
        in_mag   = 4'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_in_ready_low", 32'(in_ready), 32'd0);
            check("hold_stable", {20'd0, out_min0, out_idx0, out_min1, out_idx1},
                  {20'd0, 4'd2, 2'd2, 4'd2, 2'd1});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("release_valid_stays", 32'(out_valid), 32'd1);
        check("release_new_min0", 32'(out_min0), 32'd0);
        @(posedge clk);
        #1;

        // Reset discards a held result and a partial frame
        out_ready = 1'b0;
        frame(4'd3, 4'd3, 4'd3, 4'd3, 1'b0, '{4'd0, 2'd0, 4'd0, 2'd0});
        send(4'd1);
        send(4'd2);
        rst_n = 1'b0;
        #1;
        check("midreset_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        check("postreset_valid", 32'(out_valid), 32'd0);
        frame(4'd9, 4'd8, 4'd15, 4'd10, 1'b1, '{4'd8, 2'd1, 4'd9, 2'd0});
        @(posedge clk);
        #1;

        // Random frames with input gaps and random back-pressure
        rnd_ready = 1'b1;
        for (int f = 0; f < 24; f++) begin
            for (int s = 0; s < 4; s++) v[s] = 4'($urandom_range(0, 15));
            if (f % 3 == 0) v[2] = v[0];
            exp_q.push_back(ref_pair(v));
            for (int s = 0; s < 4; s++) begin
                send(v[s]);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("all_results_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("no_extra_result", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
